// File: rtl/fifo_burst_reader_pkg.sv
// Shared types and constants for the FIFO burst reader.
//   reader_state_t : burst FSM states
//   *_DEFAULT      : default parameter values for the reader
//   SKID_DEPTH     : skid buffer depth at the default LOG2_SKID
//   skid_depth()   : depth of a skid buffer from its log2 size
package fifo_burst_reader_pkg;

    localparam int unsigned WIDTH_DEFAULT     = 8;
    localparam int unsigned LEN_WIDTH_DEFAULT = 16;
    localparam int unsigned LOG2_SKID_DEFAULT = 2;
    localparam int unsigned SKID_DEPTH        = 2 ** LOG2_SKID_DEFAULT;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } reader_state_t;

    function automatic int unsigned skid_depth(input int unsigned log2_depth);
        return 32'd1 << log2_depth;
    endfunction

endpackage

// File: rtl/fifobram_interface.sv
// Read-side connection to a BRAM FIFO.
//   re     : read enable (sink -> FIFO)
//   empty  : FIFO has no words
//   rvalid : rdata valid, one cycle after re
//   rdata  : read word
interface fifobram_interface #(
    parameter int unsigned WIDTH = 8
);
    logic             re;
    logic             empty;
    logic             rvalid;
    logic [WIDTH-1:0] rdata;

    modport fifo_sink (
        output re,
        input  empty,
        input  rvalid,
        input  rdata
    );

    modport fifo_source (
        input  re,
        output empty,
        output rvalid,
        output rdata
    );
endinterface

// File: rtl/fifo_burst_reader_skid_buffer.sv
// Small circular buffer holding words read from the FIFO until downstream
// accepts them.
//   clk, rst_n  : clock, async active-low reset
//   push        : write push_data at the tail
//   pop         : drop the head word
//   head_data   : word at the head
//   occupancy   : number of stored words (0..2**LOG2_SKID)
module skid_buffer #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned LOG2_SKID = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic [WIDTH-1:0]     push_data,
    input  logic                 pop,
    output logic [WIDTH-1:0]     head_data,
    output logic [LOG2_SKID:0]   occupancy
);

    localparam int unsigned DEPTH = 2 ** LOG2_SKID;

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [LOG2_SKID-1:0] wr_ptr_q, wr_ptr_d;
    logic [LOG2_SKID-1:0] rd_ptr_q, rd_ptr_d;
    logic [LOG2_SKID:0]   occ_q, occ_d;
    logic                 do_push, do_pop;

    // Pointer and occupancy update; a full buffer only accepts a push alongside a pop
    always_comb begin
        do_pop   = pop && (occ_q != '0);
        do_push  = push && ((occ_q != (LOG2_SKID + 1)'(DEPTH)) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (do_push) wr_ptr_d = wr_ptr_q + (LOG2_SKID)'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + (LOG2_SKID)'(1);
        case ({do_push, do_pop})
            2'b10:   occ_d = occ_q + (LOG2_SKID + 1)'(1);
            2'b01:   occ_d = occ_q - (LOG2_SKID + 1)'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Storage needs no reset; occupancy gates every read of it
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign head_data = mem_q[rd_ptr_q];
    assign occupancy = occ_q;

endmodule

// File: rtl/fifo_burst_reader.sv
// Drains exactly `length` words per command from a BRAM FIFO and presents
// them as a valid/ready stream with a last marker.
//   clk, reset         : clock, async active-low reset
//   start, length      : command strobe (IDLE only) and burst length
//   busy, done, error  : command in progress, end-of-burst pulse, sticky
//                        unexpected-rvalid flag
//   access             : FIFO read port (re, empty, rvalid, rdata)
//   out_valid/out_data/out_last/out_ready : output stream
module fifo_burst_reader
    import fifo_burst_reader_pkg::*;
#(
    parameter int unsigned WIDTH     = WIDTH_DEFAULT,
    parameter int unsigned LEN_WIDTH = LEN_WIDTH_DEFAULT,
    parameter int unsigned LOG2_SKID = LOG2_SKID_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] length,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    fifobram_interface.fifo_sink access,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_last,
    input  logic                 out_ready
);

    localparam int unsigned DEPTH = skid_depth(LOG2_SKID);
    localparam int unsigned CW    = LOG2_SKID + 2;

    reader_state_t        state_q, state_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [LEN_WIDTH-1:0] issued_q, issued_d;
    logic [LEN_WIDTH-1:0] delivered_q, delivered_d;
    logic                 inflight_q, inflight_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 error_q, error_d;

    logic                 re_c, push_c, pop_c, credit_ok_c;
    logic [LOG2_SKID:0]   occupancy;

    skid_buffer #(
        .WIDTH     (WIDTH),
        .LOG2_SKID (LOG2_SKID)
    ) u_skid (
        .clk       (clk),
        .rst_n     (reset),
        .push      (push_c),
        .push_data (access.rdata),
        .pop       (pop_c),
        .head_data (out_data),
        .occupancy (occupancy)
    );

    // Read issue: a read is only launched if its word is guaranteed a skid slot
    always_comb begin
        credit_ok_c = (CW'(occupancy) + CW'(inflight_q)) < CW'(DEPTH);
        re_c        = (state_q == RUN) && !access.empty
                      && (issued_q != len_q) && credit_ok_c;
        push_c      = access.rvalid && inflight_q;
        pop_c       = out_valid && out_ready;
    end

    // Burst FSM and counters
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        issued_d    = issued_q;
        delivered_d = delivered_q;
        inflight_d  = re_c;
        busy_d      = busy_q;
        done_d      = 1'b0;
        error_d     = error_q | (access.rvalid & ~inflight_q);

        if (pop_c) delivered_d = delivered_q + LEN_WIDTH'(1);

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        len_d       = length;
                        issued_d    = '0;
                        delivered_d = '0;
                        busy_d      = 1'b1;
                        state_d     = RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (re_c) issued_d = issued_q + LEN_WIDTH'(1);
                if (issued_d == len_q) state_d = DRAIN;
            end
            DRAIN: begin
                // Finish in the cycle of the final handshake so done follows it directly
                if (delivered_d == len_q) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            len_q       <= '0;
            issued_q    <= '0;
            delivered_q <= '0;
            inflight_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            issued_q    <= issued_d;
            delivered_q <= delivered_d;
            inflight_q  <= inflight_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign access.re = re_c;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign out_valid = (occupancy != '0);
    assign out_last  = out_valid && (delivered_q == (len_q - LEN_WIDTH'(1)));

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: a behavioural FIFO feeds the reader, expected
// words are queued as they are written and checked as the stream emits them.
module tb_fifo_burst_reader;
    import fifo_burst_reader_pkg::*;

    localparam int unsigned WIDTH     = 8;
    localparam int unsigned LEN_WIDTH = 16;
    localparam int unsigned LOG2_SKID = 2;
    localparam int          BUDGET    = 60;

    logic                 clk       = 1'b0;
    logic                 reset     = 1'b0;
    logic                 start     = 1'b0;
    logic [LEN_WIDTH-1:0] length    = '0;
    logic                 out_ready = 1'b1;
    logic                 busy, done, error, out_valid, out_last;
    logic [WIDTH-1:0]     out_data;

    fifobram_interface #(.WIDTH(WIDTH)) access ();

    fifo_burst_reader #(
        .WIDTH     (WIDTH),
        .LEN_WIDTH (LEN_WIDTH),
        .LOG2_SKID (LOG2_SKID)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .access    (access),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [WIDTH-1:0] sb[$];

    // Behavioural FIFO with one-cycle read latency
    logic [WIDTH-1:0] fifo_q[$];
    logic             wr_en = 1'b0;
    logic [WIDTH-1:0] wr_data = '0;
    logic             flush = 1'b0;
    logic             spur = 1'b0;
    logic             fifo_rvalid = 1'b0;
    logic [WIDTH-1:0] fifo_rdata = '0;
    int               fifo_cnt = 0;
    int               re_count = 0;
    bit               re_on_empty = 1'b0;

    always @(posedge clk) begin
        fifo_rvalid <= 1'b0;
        if (flush) begin
            fifo_q.delete();
        end else begin
            if (access.re) begin
                re_count <= re_count + 1;
                if (fifo_q.size() == 0) begin
                    re_on_empty <= 1'b1;
                end else begin
                    fifo_rdata  <= fifo_q.pop_front();
                    fifo_rvalid <= 1'b1;
                end
            end
            if (wr_en) fifo_q.push_back(wr_data);
        end
        if (spur) begin
            fifo_rvalid <= 1'b1;
            fifo_rdata  <= 8'hEE;
        end
        fifo_cnt <= fifo_q.size();
    end

    assign access.empty  = (fifo_cnt == 0);
    assign access.rvalid = fifo_rvalid;
    assign access.rdata  = fifo_rdata;

    // Independent credit watch: words held plus words in flight never exceed the skid depth
    int m_occ = 0;
    int m_inf = 0;
    bit credit_viol = 1'b0;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_occ <= 0;
            m_inf <= 0;
        end else begin
            if (access.re && (m_occ + m_inf) >= int'(SKID_DEPTH)) credit_viol <= 1'b1;
            m_inf <= access.re ? 1 : 0;
            m_occ <= m_occ + (fifo_rvalid ? 1 : 0) - ((out_valid && out_ready) ? 1 : 0);
        end
    end

    int done_cnt = 0;
    int cyc = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    // Wait for the next output handshake; returns at the negedge before it commits
    task automatic wait_word(input bit toggle, output bit got, output logic [WIDTH-1:0] data,
                             output logic last, output int when);
        got  = 1'b0;
        data = '0;
        last = 1'b0;
        when = 0;
        for (int c = 0; c < BUDGET && !got; c++) begin
            @(negedge clk);
            out_ready = toggle ? ~out_ready : 1'b1;
            if (out_valid && out_ready) begin
                got  = 1'b1;
                data = out_data;
                last = out_last;
                when = cyc;
            end
        end
    endtask

    task automatic preload(input int n, input logic [WIDTH-1:0] base, input bit expect_out);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_data = WIDTH'(base + WIDTH'(i));
            if (expect_out) sb.push_back(wr_data);
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic do_flush();
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        sb.delete();
    endtask

    task automatic do_start(input int len);
        @(negedge clk);
        start  = 1'b1;
        length = LEN_WIDTH'(len);
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({busy, done, error, out_valid, out_last, access.re} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 000000",
                     {busy, done, error, out_valid, out_last, access.re});
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_full_burst();
        bit got; logic [WIDTH-1:0] d; logic l; int w, first;
        preload(8, 8'h00, 1'b1);
        do_start(8);
        first = 0;
        for (int i = 0; i < 8; i++) begin
            wait_word(1'b0, got, d, l, w);
            if (i == 0) first = w;
            checks++;
            if (!got) begin
                errors++; $display("FAIL full_timeout: word %0d not seen", i);
            end else begin
                if (d !== sb.pop_front() || l !== (i == 7) || w != first + i) begin
                    errors++;
                    $display("FAIL full_word%0d: got data=%0h last=%b cyc=%0d want data=%0h last=%b cyc=%0d",
                             i, d, l, w, i, (i == 7), first + i);
                end
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || error !== 1'b0) begin
            errors++; $display("FAIL full_done: got done=%b error=%b want 1 0", done, error);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL full_done_pulse: got done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_partial();
        bit got; logic [WIDTH-1:0] d; logic l; int w, re0;
        do_flush();
        preload(8, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) sb.push_back(WIDTH'(i));
        re0 = re_count;
        do_start(5);
        for (int i = 0; i < 5; i++) begin
            wait_word(1'b0, got, d, l, w);
            checks++;
            if (!got || d !== sb.pop_front() || l !== (i == 4)) begin
                errors++;
                $display("FAIL partial_word%0d: got valid=%b data=%0h last=%b want data=%0h last=%b",
                         i, got, d, l, i, (i == 4));
            end
        end
        repeat (4) @(negedge clk);
        checks++;
        if (re_count - re0 != 5 || fifo_cnt != 3 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL partial_counts: got re=%0d left=%0d valid=%b want 5 3 0",
                     re_count - re0, fifo_cnt, out_valid);
        end
    endtask

    task automatic test_backpressure();
        bit got; logic [WIDTH-1:0] d; logic l; int w, dc;
        do_flush();
        preload(16, 8'h20, 1'b1);
        dc = done_cnt;
        do_start(16);
        for (int i = 0; i < 16; i++) begin
            wait_word(1'b1, got, d, l, w);
            checks++;
            if (!got || d !== sb[0] || l !== (i == 15)) begin
                errors++;
                $display("FAIL bp_word%0d: got valid=%b data=%0h last=%b want data=%0h last=%b",
                         i, got, d, l, sb[0], (i == 15));
            end
            if (sb.size() > 0) void'(sb.pop_front());
        end
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (credit_viol !== 1'b0 || done_cnt - dc != 1 || fifo_cnt != 0) begin
            errors++;
            $display("FAIL bp_credit: got viol=%b dones=%0d left=%0d want 0 1 0",
                     credit_viol, done_cnt - dc, fifo_cnt);
        end
    endtask

    task automatic test_slow_fifo();
        bit got; logic [WIDTH-1:0] d; logic l; int w, dc;
        do_flush();
        dc = done_cnt;
        do_start(4);
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    repeat (2) @(negedge clk);
                    wr_en   = 1'b1;
                    wr_data = WIDTH'(8'h40 + WIDTH'(i));
                    sb.push_back(wr_data);
                    @(negedge clk);
                    wr_en = 1'b0;
                end
            end
            begin
                for (int i = 0; i < 4; i++) begin
                    wait_word(1'b0, got, d, l, w);
                    checks++;
                    if (!got || d !== WIDTH'(8'h40 + WIDTH'(i)) || l !== (i == 3)) begin
                        errors++;
                        $display("FAIL slow_word%0d: got valid=%b data=%0h last=%b want data=%0h last=%b",
                                 i, got, d, l, 8'h40 + i, (i == 3));
                    end
                    if (sb.size() > 0) void'(sb.pop_front());
                end
            end
        join
        repeat (5) @(negedge clk);
        checks++;
        if (re_on_empty !== 1'b0 || done_cnt - dc != 1) begin
            errors++;
            $display("FAIL slow_done: got re_on_empty=%b dones=%0d want 0 1", re_on_empty, done_cnt - dc);
        end
    endtask

    task automatic test_zero_length();
        int re0;
        re0 = re_count;
        do_start(0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL zero_done: got done=%b busy=%b want 1 0", done, busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL zero_pulse: got done=%b busy=%b want 0 0", done, busy);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (re_count != re0) begin
            errors++; $display("FAIL zero_no_re: got %0d reads want 0", re_count - re0);
        end
    endtask

    task automatic test_reset_mid_burst();
        bit got; logic [WIDTH-1:0] d; logic l; int w, dc;
        do_flush();
        preload(10, 8'h60, 1'b1);
        do_start(10);
        for (int i = 0; i < 3; i++) begin
            wait_word(1'b0, got, d, l, w);
            checks++;
            if (!got || d !== sb.pop_front()) begin
                errors++;
                $display("FAIL rst_pre_word%0d: got valid=%b data=%0h want %0h", i, got, d, 8'h60 + i);
            end
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if ({busy, done, out_valid, out_last, access.re} !== 5'b0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got %b want 00000", {busy, done, out_valid, out_last, access.re});
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        sb.delete();
        sb.push_back(fifo_q[0]);
        sb.push_back(fifo_q[1]);
        dc = done_cnt;
        do_start(2);
        for (int i = 0; i < 2; i++) begin
            wait_word(1'b0, got, d, l, w);
            checks++;
            if (!got || d !== sb[0] || l !== (i == 1)) begin
                errors++;
                $display("FAIL rst_post_word%0d: got valid=%b data=%0h last=%b want data=%0h last=%b",
                         i, got, d, l, sb[0], (i == 1));
            end
            void'(sb.pop_front());
        end
        repeat (3) @(negedge clk);
        checks++;
        if (done_cnt - dc != 1 || error !== 1'b0) begin
            errors++;
            $display("FAIL rst_post_done: got dones=%0d error=%b want 1 0", done_cnt - dc, error);
        end
    endtask

    task automatic test_error();
        @(negedge clk);
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        @(negedge clk);
        checks++;
        if (error !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL error_set: got error=%b valid=%b want 1 0", error, out_valid);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (error !== 1'b1) begin
            errors++; $display("FAIL error_sticky: got %b want 1", error);
        end
    endtask

    initial begin
        test_reset();
        test_full_burst();
        test_partial();
        test_backpressure();
        test_slow_fifo();
        test_zero_length();
        test_reset_mid_burst();
        test_error();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
